// File: rtl/rx_packet_buffer.sv
// rx_packet_buffer: ping-pong staging of received MAC frames.
// Each good frame's first 2**ADDR_WIDTH bytes land in one of two banks.
// The responder reads them at random and releases the bank when it is done.
// The write pointer and the read pointer alternate, so frames leave in the order they arrived.
module rx_packet_buffer #(
  parameter int ADDR_WIDTH = 6,
  parameter int MIN_LEN    = 42
) (
  input  logic                  mac_clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  rx_last,
  input  logic                  rx_error,
  output logic                  packet_ready,
  input  logic                  done_with_packet,
  input  logic [ADDR_WIDTH-1:0] packet_read_addr,
  output logic [7:0]            packet_data,
  output logic [10:0]           packet_len,
  output logic [15:0]           rx_drop_count
);

  localparam int          DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [10:0] DEPTH_L = 11'(DEPTH);
  localparam logic [10:0] MIN_L   = 11'(MIN_LEN);

  typedef enum logic [1:0] {W_IDLE, W_STORE, W_DISCARD} wstate_e;

  wstate_e          wstate_q, wstate_d;
  logic [10:0]      wr_cnt_q, wr_cnt_d;
  logic [1:0]       full_q, full_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             done_prev_q;
  logic [1:0][10:0] len_q, len_d;
  logic [15:0]      drop_q, drop_d;
  logic [7:0]       pdata_q;

  logic [7:0]            mem [2][DEPTH];
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic                  frame_end, drop_inc;
  logic [10:0]           final_cnt, cnt_inc;

  // Write FSM next state, the commit/drop decision, and the release of the read bank
  always_comb begin
    wstate_d  = wstate_q;
    wr_cnt_d  = wr_cnt_q;
    full_d    = full_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    len_d     = len_q;
    drop_d    = drop_q;
    mem_we    = 1'b0;
    mem_waddr = '0;
    frame_end = 1'b0;
    drop_inc  = 1'b0;
    final_cnt = '0;
    cnt_inc   = (wr_cnt_q == 11'h7FF) ? wr_cnt_q : wr_cnt_q + 11'd1;

    case (wstate_q)
      W_IDLE: begin
        if (rx_valid) begin
          if (!full_q[wr_ptr_q]) begin
            mem_we   = 1'b1;
            wr_cnt_d = 11'd1;
            // A one-byte frame ends right here and is judged like any other frame end
            if (rx_last) begin
              frame_end = 1'b1;
              final_cnt = 11'd1;
            end else begin
              wstate_d = W_STORE;
            end
          end else if (rx_last) begin
            drop_inc = 1'b1;
          end else begin
            wstate_d = W_DISCARD;
          end
        end
      end
      W_STORE: begin
        if (rx_valid) begin
          // Bytes past the bank depth are still counted, so packet_len keeps the true frame size
          mem_we    = (wr_cnt_q < DEPTH_L);
          mem_waddr = wr_cnt_q[ADDR_WIDTH-1:0];
          wr_cnt_d  = cnt_inc;
          if (rx_last) begin
            frame_end = 1'b1;
            final_cnt = cnt_inc;
            wstate_d  = W_IDLE;
          end
        end
      end
      W_DISCARD: begin
        if (rx_valid && rx_last) begin
          drop_inc = 1'b1;
          wstate_d = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase

    if (frame_end) begin
      if (!rx_error && final_cnt >= MIN_L) begin
        full_d[wr_ptr_q] = 1'b1;
        len_d[wr_ptr_q]  = final_cnt;
        wr_ptr_d         = ~wr_ptr_q;
      end else begin
        drop_inc = 1'b1;
      end
    end

    if (drop_inc && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;

    // Commit only targets a free bank, so it can never be the bank being released
    if (done_with_packet && !done_prev_q && full_q[rd_ptr_q]) begin
      full_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = ~rd_ptr_q;
    end
  end

  // State registers: the FSM, the bank flags and pointers, the lengths, the drop counter and the read data
  always_ff @(posedge mac_clk) begin
    if (reset) begin
      wstate_q    <= W_IDLE;
      wr_cnt_q    <= '0;
      full_q      <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      done_prev_q <= 1'b0;
      len_q       <= '0;
      drop_q      <= '0;
      pdata_q     <= '0;
    end else begin
      wstate_q    <= wstate_d;
      wr_cnt_q    <= wr_cnt_d;
      full_q      <= full_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      done_prev_q <= done_with_packet;
      len_q       <= len_d;
      drop_q      <= drop_d;
      pdata_q     <= mem[rd_ptr_q][packet_read_addr];
    end
  end

  // Bank RAM write port; the contents are left unreset
  always_ff @(posedge mac_clk) begin
    if (mem_we && !reset) mem[wr_ptr_q][mem_waddr] <= rx_data;
  end

  assign packet_ready  = full_q[rd_ptr_q];
  assign packet_len    = len_q[rd_ptr_q];
  assign packet_data   = pdata_q;
  assign rx_drop_count = drop_q;

endmodule
